// File: rtl/mgmt_sram_arbiter.sv
// mgmt_sram_arbiter
//   Arbitrates the management CPU (read/write) and the housekeeping port
//   (read-only) onto one single-port, byte-writable, banked RAM interface.
//   The CPU wins contention until housekeeping has been refused STARVE_MAX
//   cycles in a row; then housekeeping wins once. Read data returns two
//   cycles after the grant through a registered pipeline.
// Ports
//   core_clk, core_rstn                    clock, async active-low reset
//   cpu_req/wen/addr/wdata -> cpu_gnt      CPU request, combinational grant
//   cpu_rvalid, cpu_rdata                  CPU read return (rdata held)
//   ro_req/addr -> ro_gnt                  housekeeping read request / grant
//   ro_rvalid, ro_rdata                    housekeeping read return (held)
//   ram_en/wen/addr/wdata, ram_rdata       banked RAM macro interface
module mgmt_sram_arbiter #(
   parameter int DW         = 32,
   parameter int AW         = 10,
   parameter int NBANKS     = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic                   core_clk,
   input  logic                   core_rstn,
   input  logic                   cpu_req,
   input  logic [DW/8-1:0]        cpu_wen,
   input  logic [AW-1:0]          cpu_addr,
   input  logic [DW-1:0]          cpu_wdata,
   output logic                   cpu_gnt,
   output logic                   cpu_rvalid,
   output logic [DW-1:0]          cpu_rdata,
   input  logic                   ro_req,
   input  logic [AW-1:0]          ro_addr,
   output logic                   ro_gnt,
   output logic                   ro_rvalid,
   output logic [DW-1:0]          ro_rdata,
   output logic [NBANKS-1:0]      ram_en,
   output logic [DW/8-1:0]        ram_wen,
   output logic [AW-(NBANKS>1 ? $clog2(NBANKS) : 0)-1:0] ram_addr,
   output logic [DW-1:0]          ram_wdata,
   input  logic [NBANKS*DW-1:0]   ram_rdata
);

   localparam int BW  = (NBANKS > 1) ? $clog2(NBANKS) : 0;
   localparam int BIW = (NBANKS > 1) ? BW : 1;       // bank index register width
   localparam int SW  = $clog2(STARVE_MAX + 1);

   logic [SW-1:0]     starve_cnt;
   logic              ro_prio;
   logic [AW-1:0]     sel_addr;
   logic [BIW-1:0]    bank_idx;
   logic              any_gnt;
   logic              rd_gnt;

   // Read-return stage 1: owner (1 = RO) and bank of the read issued last cycle
   logic              rd_vld_q;
   logic              rd_own_q;
   logic [BIW-1:0]    rd_bank_q;
   logic [DW-1:0]     rd_sel;

   // ---------------- arbitration ----------------
   // Gating with core_rstn keeps the RAM idle while reset is held.
   assign ro_prio = ro_req && (starve_cnt == SW'(STARVE_MAX));
   assign cpu_gnt = core_rstn && cpu_req && !ro_prio;
   assign ro_gnt  = core_rstn && ro_req && (!cpu_req || ro_prio);
   assign any_gnt = cpu_gnt || ro_gnt;
   assign rd_gnt  = ro_gnt || (cpu_gnt && (cpu_wen == '0));

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn)
         starve_cnt <= '0;
      else if (ro_req && !ro_gnt) begin
         if (starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
      end else
         starve_cnt <= '0;
   end

   // ---------------- RAM drive ----------------
   assign sel_addr  = ro_gnt ? ro_addr : cpu_addr;
   assign ram_wdata = cpu_wdata;
   assign ram_wen   = cpu_gnt ? cpu_wen : '0;

   generate
      if (NBANKS > 1) begin : g_banked
         assign bank_idx = sel_addr[AW-1 -: BW];
         assign ram_addr = sel_addr[AW-BW-1:0];
      end else begin : g_single
         assign bank_idx = 1'b0;
         assign ram_addr = sel_addr;
      end
   endgenerate

   assign ram_en = any_gnt ? (NBANKS'(1) << bank_idx) : '0;

   // ---------------- read return ----------------
   always_comb begin
      rd_sel = '0;
      for (int k = 0; k < NBANKS; k++)
         if (rd_bank_q == BIW'(k))
            rd_sel = ram_rdata[k*DW +: DW];
   end

   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         rd_vld_q   <= 1'b0;
         rd_own_q   <= 1'b0;
         rd_bank_q  <= '0;
         cpu_rvalid <= 1'b0;
         ro_rvalid  <= 1'b0;
         cpu_rdata  <= '0;
         ro_rdata   <= '0;
      end else begin
         rd_vld_q  <= rd_gnt;
         rd_own_q  <= ro_gnt;
         rd_bank_q <= bank_idx;
         cpu_rvalid <= rd_vld_q && !rd_own_q;
         ro_rvalid  <= rd_vld_q &&  rd_own_q;
         if (rd_vld_q && !rd_own_q) cpu_rdata <= rd_sel;
         if (rd_vld_q &&  rd_own_q) ro_rdata  <= rd_sel;
      end
   end

endmodule

// File: tb/tb_mgmt_sram_arbiter.sv
// tb_mgmt_sram_arbiter
//   Directed bench for mgmt_sram_arbiter with a behavioural 4-bank RAM.
//   Untouched RAM words hold 32'h5A000000 | word_address.
module tb_mgmt_sram_arbiter;

   localparam int DW = 32, AW = 10, NB = 4;

   logic             core_clk = 1'b0;
   logic             core_rstn;
   logic             cpu_req;
   logic [3:0]       cpu_wen;
   logic [AW-1:0]    cpu_addr;
   logic [DW-1:0]    cpu_wdata;
   logic             cpu_gnt, cpu_rvalid;
   logic [DW-1:0]    cpu_rdata;
   logic             ro_req;
   logic [AW-1:0]    ro_addr;
   logic             ro_gnt, ro_rvalid;
   logic [DW-1:0]    ro_rdata;
   logic [NB-1:0]    ram_en;
   logic [3:0]       ram_wen;
   logic [7:0]       ram_addr;
   logic [DW-1:0]    ram_wdata;
   logic [NB-1:0][DW-1:0] rd_q;

   int compared = 0;
   int mismatched = 0;

   always #5 core_clk = ~core_clk;

   mgmt_sram_arbiter #(.DW(DW), .AW(AW), .NBANKS(NB), .STARVE_MAX(4)) dut (
      .core_clk(core_clk), .core_rstn(core_rstn),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .ro_req(ro_req), .ro_addr(ro_addr),
      .ro_gnt(ro_gnt), .ro_rvalid(ro_rvalid), .ro_rdata(ro_rdata),
      .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(rd_q)
   );

   // Behavioural RAM: registered read, byte-masked write, one-cycle latency.
   logic [DW-1:0] mem [NB][256];
   logic          mem_init = 1'b0;
   always @(posedge core_clk) begin
      if (!mem_init) begin
         for (int b = 0; b < NB; b++)
            for (int a = 0; a < 256; a++)
               mem[b][a] <= 32'h5A00_0000 | (b * 256 + a);
         mem_init <= 1'b1;
      end else begin
         for (int b = 0; b < NB; b++)
            if (ram_en[b]) begin
               rd_q[b] <= mem[b][ram_addr];
               for (int y = 0; y < 4; y++)
                  if (ram_wen[y]) mem[b][ram_addr][y*8 +: 8] <= ram_wdata[y*8 +: 8];
            end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge core_clk);
      #1;
   endtask

   initial begin
      core_rstn = 1'b0;
      cpu_req = 1'b1; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
      ro_req = 1'b1;  ro_addr = '0;

      // ---- reset state: requests present but nothing granted ----
      @(negedge core_clk);
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_ro_gnt", ro_gnt, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_rvalid", {cpu_rvalid, ro_rvalid}, 0);
      chk("rst_rdata", {cpu_rdata, ro_rdata}, 0);
      tick; tick;
      cpu_req = 1'b0; ro_req = 1'b0;
      core_rstn = 1'b1;
      tick;

      // ---- 1: full write then read of 0x105 (bank 1) ----
      cpu_req = 1'b1; cpu_wen = 4'hF; cpu_addr = 10'h105; cpu_wdata = 32'hDEADBEEF;
      @(negedge core_clk);
      chk("t1_wr_gnt", cpu_gnt, 1);
      chk("t1_wr_en", ram_en, 4'b0010);
      chk("t1_wr_wen", ram_wen, 4'hF);
      chk("t1_wr_addr", ram_addr, 8'h05);
      tick;
      cpu_wen = 4'h0;
      @(negedge core_clk);
      chk("t1_rd_gnt", cpu_gnt, 1);
      chk("t1_rd_en", ram_en, 4'b0010);
      chk("t1_rd_wen", ram_wen, 0);
      tick;
      cpu_req = 1'b0;
      @(negedge core_clk);
      chk("t1_no_early_rvalid", cpu_rvalid, 0);   // also: the write produced none
      tick;
      @(negedge core_clk);
      chk("t1_rvalid", cpu_rvalid, 1);
      chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
      chk("t1_ro_rvalid", ro_rvalid, 0);
      tick;
      @(negedge core_clk);
      chk("t1_pulse", cpu_rvalid, 0);
      chk("t1_hold", cpu_rdata, 32'hDEADBEEF);

      // ---- 2: byte-2 write, readback merges bytes ----
      cpu_req = 1'b1; cpu_wen = 4'b0100; cpu_wdata = 32'h00AA0000;
      tick;
      cpu_wen = 4'h0;
      tick;
      cpu_req = 1'b0;
      tick;
      @(negedge core_clk);
      chk("t2_rvalid", cpu_rvalid, 1);
      chk("t2_rdata", cpu_rdata, 32'hDEAABEEF);
      tick;

      // ---- 3: starvation bound ----
      cpu_req = 1'b1; cpu_wen = 4'h0; cpu_addr = 10'h000;
      ro_req = 1'b1;  ro_addr = 10'h3FF;
      for (int i = 0; i < 4; i++) begin
         @(negedge core_clk);
         chk("t3_cpu_wins", {cpu_gnt, ro_gnt}, 2'b10);
         tick;
      end
      @(negedge core_clk);
      chk("t3_ro_wins", {cpu_gnt, ro_gnt}, 2'b01);
      chk("t3_ro_en", ram_en, 4'b1000);
      chk("t3_ro_addr", ram_addr, 8'hFF);
      chk("t3_ro_wen", ram_wen, 0);
      tick;
      ro_req = 1'b0;
      @(negedge core_clk);
      chk("t3_cpu_again", {cpu_gnt, ro_gnt}, 2'b10);
      chk("t3_cpu_ret", cpu_rvalid, 1);
      chk("t3_cpu_data", cpu_rdata, 32'h5A000000);
      tick;
      cpu_req = 1'b0;
      @(negedge core_clk);
      chk("t3_ro_ret", {cpu_rvalid, ro_rvalid}, 2'b01);
      chk("t3_ro_data", ro_rdata, 32'h5A0003FF);
      tick;
      @(negedge core_clk);
      chk("t3_cpu_ret2", {cpu_rvalid, ro_rvalid}, 2'b10);
      tick;

      // ---- 4: same-cycle CPU write / RO read to 0x010 ----
      cpu_req = 1'b1; cpu_wen = 4'hF; cpu_addr = 10'h010; cpu_wdata = 32'h12345678;
      ro_req = 1'b1;  ro_addr = 10'h010;
      @(negedge core_clk);
      chk("t4_cpu_first", {cpu_gnt, ro_gnt}, 2'b10);
      tick;
      cpu_req = 1'b0; cpu_wen = 4'h0;
      @(negedge core_clk);
      chk("t4_ro_next", {cpu_gnt, ro_gnt}, 2'b01);
      chk("t4_ro_en", ram_en, 4'b0001);
      tick;
      ro_req = 1'b0;
      tick;
      @(negedge core_clk);
      chk("t4_ro_rvalid", ro_rvalid, 1);
      chk("t4_ro_new", ro_rdata, 32'h12345678);
      tick;

      // ---- 5: alternating back-to-back reads across banks ----
      cpu_req = 1'b1; cpu_addr = 10'h010;
      @(negedge core_clk);
      chk("t5_c1_gnt", cpu_gnt, 1);
      tick;
      cpu_req = 1'b0; ro_req = 1'b1; ro_addr = 10'h105;
      @(negedge core_clk);
      chk("t5_c2_gnt", ro_gnt, 1);
      chk("t5_c2_en", ram_en, 4'b0010);
      tick;
      cpu_req = 1'b1; cpu_addr = 10'h2AB; ro_req = 1'b0;
      @(negedge core_clk);
      chk("t5_c3_gnt", cpu_gnt, 1);
      chk("t5_c3_en", ram_en, 4'b0100);
      chk("t5_c3_rv", {cpu_rvalid, ro_rvalid}, 2'b10);
      chk("t5_c3_data", cpu_rdata, 32'h12345678);
      tick;
      cpu_req = 1'b0; ro_req = 1'b1; ro_addr = 10'h3C0;
      @(negedge core_clk);
      chk("t5_c4_gnt", ro_gnt, 1);
      chk("t5_c4_rv", {cpu_rvalid, ro_rvalid}, 2'b01);
      chk("t5_c4_data", ro_rdata, 32'hDEAABEEF);
      tick;
      ro_req = 1'b0;
      @(negedge core_clk);
      chk("t5_c5_rv", {cpu_rvalid, ro_rvalid}, 2'b10);
      chk("t5_c5_data", cpu_rdata, 32'h5A0002AB);
      tick;
      @(negedge core_clk);
      chk("t5_c6_rv", {cpu_rvalid, ro_rvalid}, 2'b01);
      chk("t5_c6_data", ro_rdata, 32'h5A0003C0);
      tick;
      @(negedge core_clk);
      chk("t5_idle_rv", {cpu_rvalid, ro_rvalid}, 2'b00);
      chk("t5_cpu_hold", cpu_rdata, 32'h5A0002AB);
      tick;

      // ---- 6: reset one cycle after a read grant ----
      cpu_req = 1'b1; cpu_addr = 10'h105; ro_req = 1'b1; ro_addr = 10'h3FF;
      @(negedge core_clk);
      chk("t6_gnt", {cpu_gnt, ro_gnt}, 2'b10);
      tick;
      core_rstn = 1'b0;
      @(negedge core_clk);
      chk("t6_rst_gnt", {cpu_gnt, ro_gnt}, 2'b00);
      chk("t6_rst_en", ram_en, 0);
      chk("t6_rst_rv", {cpu_rvalid, ro_rvalid}, 2'b00);
      chk("t6_rst_data", {cpu_rdata, ro_rdata}, 0);
      tick;
      core_rstn = 1'b1;
      @(negedge core_clk);
      chk("t6_r0_gnt", {cpu_gnt, ro_gnt}, 2'b10);
      chk("t6_r0_rv", {cpu_rvalid, ro_rvalid}, 2'b00);
      tick;
      @(negedge core_clk);
      chk("t6_r1_gnt", {cpu_gnt, ro_gnt}, 2'b10);
      chk("t6_r1_rv", {cpu_rvalid, ro_rvalid}, 2'b00);
      chk("t6_r1_data", cpu_rdata, 0);
      tick;
      // Counter restarted from 0: two more CPU wins, then RO on the 5th.
      for (int i = 0; i < 2; i++) begin
         @(negedge core_clk);
         chk("t6_cpu_wins", {cpu_gnt, ro_gnt}, 2'b10);
         tick;
      end
      @(negedge core_clk);
      chk("t6_ro_wins", {cpu_gnt, ro_gnt}, 2'b01);
      tick;
      cpu_req = 1'b0; ro_req = 1'b0;
      tick; tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
